// File: rtl/queue_ctrl_pkg.sv
// Shared types and default sizes for the serial-in byte queue controller.
package queue_ctrl_pkg;

  localparam int DEF_DATA_W      = 8;
  localparam int DEF_SYNC_STAGES = 2;

  // Byte assembly / hand-off sequencing states.
  typedef enum logic [1:0] {
    S_RECV = 2'd0,
    S_HOLD = 2'd1,
    S_ENQ  = 2'd2
  } state_t;

  // Sticky error accumulation: once set, only reset clears it.
  function automatic logic err_next(input logic err_cur, input logic enq_rej,
                                    input logic deq_rej);
    return err_cur | enq_rej | deq_rej;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Multi-flop synchronizer for a slow asynchronous strobe, followed by a
// rising-edge detector. EARLY=1 exposes the detector output one cycle before
// its registered copy, so a consumer that registers it lands on the same cycle
// as the registered pulse of an EARLY=0 instance.
module edge_sync #(
  parameter int STAGES = 2,
  parameter bit EARLY  = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic pulse_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              pulse_q;
  logic              pulse_d;

  // Rising edge of the synchronized level: high now, low one cycle ago.
  assign pulse_d = sync_q[STAGES-1] & ~prev_q;

  // Synchronizer chain, previous-level flop and registered edge pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[STAGES-2:0], async_i};
      prev_q  <= sync_q[STAGES-1];
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = EARLY ? pulse_d : pulse_q;

endmodule

// File: rtl/queue_ctrl.sv
// Serial-in byte queue controller: collects LSB-first bits into a byte,
// hands it to an external queue on request and issues dequeue strobes,
// with dequeue taking priority so the two strobes never coincide.
module queue_ctrl
  import queue_ctrl_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int AUTO_ENQ    = 0
) (
  input  logic              clock_1MHz,
  input  logic              rst,
  input  logic              data_in,
  input  logic              write_in,
  input  logic              enqueue_in,
  input  logic              dequeue_in,
  input  logic              q_full,
  input  logic              q_empty,
  output logic              q_enq_o,
  output logic              q_deq_o,
  output logic [DATA_W-1:0] q_wdata_o,
  output logic              status_out,
  output logic              err_o
);

  localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Synchronized strobes and data.
  logic wr_p_s;
  logic enq_p_s;
  logic deq_e_s;
  logic data_s;
  logic [SYNC_STAGES:0] dsync_q;

  // FSM and datapath state.
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic               status_q, status_d;
  logic               q_enq_q, q_enq_d;
  logic               q_deq_q, q_deq_d;
  logic               deq_pend_q, deq_pend_d;
  logic               err_q, err_d;
  logic               enq_err_s;
  logic               deq_err_s;
  logic               deq_go_s;
  logic               enq_req_s;

  edge_sync #(.STAGES(SYNC_STAGES), .EARLY(1'b0)) u_sync_wr (
    .clk_i   (clock_1MHz),
    .rst_ni  (rst),
    .async_i (write_in),
    .pulse_o (wr_p_s)
  );

  edge_sync #(.STAGES(SYNC_STAGES), .EARLY(1'b0)) u_sync_enq (
    .clk_i   (clock_1MHz),
    .rst_ni  (rst),
    .async_i (enqueue_in),
    .pulse_o (enq_p_s)
  );

  // The dequeue detector feeds a registered strobe, so it taps the edge one
  // cycle early; the strobe then appears alongside the other pulses.
  edge_sync #(.STAGES(SYNC_STAGES), .EARLY(1'b1)) u_sync_deq (
    .clk_i   (clock_1MHz),
    .rst_ni  (rst),
    .async_i (dequeue_in),
    .pulse_o (deq_e_s)
  );

  // Data synchronizer one flop deeper than the strobe chain so the bit value
  // lines up with the registered write pulse.
  always_ff @(posedge clock_1MHz or negedge rst) begin
    if (!rst) begin
      dsync_q <= '0;
    end else begin
      dsync_q <= {dsync_q[SYNC_STAGES-1:0], data_in};
    end
  end

  assign data_s = dsync_q[SYNC_STAGES];

  // Dequeue path: issue, one-deep latch for back-to-back requests, rejects.
  always_comb begin
    deq_go_s   = 1'b0;
    deq_pend_d = deq_pend_q;
    deq_err_s  = 1'b0;
    q_deq_d    = 1'b0;
    if (deq_pend_q) begin
      deq_go_s   = 1'b1;
      deq_pend_d = 1'b0;
      if (deq_e_s) begin
        deq_err_s = 1'b1;
      end else begin
        deq_err_s = 1'b0;
      end
    end else if (deq_e_s) begin
      if (q_deq_q) begin
        deq_pend_d = 1'b1;
      end else begin
        deq_go_s = 1'b1;
      end
    end else begin
      deq_go_s = 1'b0;
    end
    if (deq_go_s) begin
      if (q_empty) begin
        deq_err_s = 1'b1;
      end else begin
        q_deq_d = 1'b1;
      end
    end else begin
      q_deq_d = 1'b0;
    end
  end

  // Byte-assembly FSM next state; an enqueue yields to a same-cycle dequeue.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    q_enq_d   = 1'b0;
    enq_err_s = 1'b0;
    enq_req_s = enq_p_s || (AUTO_ENQ != 0);
    case (state_q)
      S_RECV: begin
        // Once a byte is under way keep collecting, even if full appears.
        if (wr_p_s && (status_q || (bit_cnt_q != '0))) begin
          shift_d[bit_cnt_q] = data_s;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = S_HOLD;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_ONE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
      end
      S_HOLD: begin
        if (enq_req_s) begin
          if (q_full) begin
            enq_err_s = 1'b1;
          end else begin
            state_d = S_ENQ;
            q_enq_d = ~q_deq_d;
          end
        end else begin
          state_d = S_HOLD;
        end
      end
      S_ENQ: begin
        if (q_enq_q) begin
          state_d = S_RECV;
        end else begin
          q_enq_d = ~q_deq_d;
        end
      end
      default: begin
        state_d   = S_RECV;
        bit_cnt_d = '0;
      end
    endcase
  end

  // Ready indication and sticky error next values.
  always_comb begin
    status_d = (state_d == S_RECV) && !q_full;
    err_d    = err_next(err_q, enq_err_s, deq_err_s);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clock_1MHz or negedge rst) begin
    if (!rst) begin
      state_q    <= S_RECV;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      status_q   <= 1'b0;
      q_enq_q    <= 1'b0;
      q_deq_q    <= 1'b0;
      deq_pend_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      status_q   <= status_d;
      q_enq_q    <= q_enq_d;
      q_deq_q    <= q_deq_d;
      deq_pend_q <= deq_pend_d;
      err_q      <= err_d;
    end
  end

  assign q_enq_o    = q_enq_q;
  assign q_deq_o    = q_deq_q;
  assign q_wdata_o  = shift_q;
  assign status_out = status_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_queue_ctrl.sv
// Self-checking bench for queue_ctrl: directed scenarios plus a randomized
// sequence checked against a byte-level reference model.
module tb_queue_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic data_in = 1'b0, write_in = 1'b0, enqueue_in = 1'b0, dequeue_in = 1'b0;
  logic q_full = 1'b0, q_empty = 1'b1;
  logic q_enq_o, q_deq_o, status_out, err_o;
  logic [7:0] q_wdata_o;

  logic a_enq_in = 1'b0, a_deq_in = 1'b0, a_full = 1'b0, a_empty = 1'b1;
  logic a_q_enq, a_q_deq, a_status, a_err;
  logic [7:0] a_wdata;

  int tests = 0, fails = 0;
  int cyc = 0;
  int enq_cnt = 0, deq_cnt = 0, overlap_cnt = 0, enq_cyc = 0, deq_cyc = 0;
  int a_enq_cnt = 0, a_enq_cyc = 0, a_fall_cyc = 0, m_fall_cyc = 0;
  int last_wr_cyc = 0;
  logic a_status_prev = 1'b0, m_status_prev = 1'b0;
  logic [7:0] enq_bytes[$];
  logic [7:0] a_bytes[$];

  queue_ctrl #(.DATA_W(8), .SYNC_STAGES(2), .AUTO_ENQ(0)) dut (
    .clock_1MHz(clk), .rst(rst), .data_in(data_in), .write_in(write_in),
    .enqueue_in(enqueue_in), .dequeue_in(dequeue_in), .q_full(q_full),
    .q_empty(q_empty), .q_enq_o(q_enq_o), .q_deq_o(q_deq_o),
    .q_wdata_o(q_wdata_o), .status_out(status_out), .err_o(err_o)
  );

  queue_ctrl #(.DATA_W(8), .SYNC_STAGES(2), .AUTO_ENQ(1)) dut_a (
    .clock_1MHz(clk), .rst(rst), .data_in(data_in), .write_in(write_in),
    .enqueue_in(a_enq_in), .dequeue_in(a_deq_in), .q_full(a_full),
    .q_empty(a_empty), .q_enq_o(a_q_enq), .q_deq_o(a_q_deq),
    .q_wdata_o(a_wdata), .status_out(a_status), .err_o(a_err)
  );

  always #5 clk = ~clk;

  // Cycle counter: number of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    m_status_prev <= status_out;
    a_status_prev <= a_status;
    if (q_enq_o) begin
      enq_cnt <= enq_cnt + 1;
      enq_cyc <= cyc;
      enq_bytes.push_back(q_wdata_o);
    end
    if (q_deq_o) begin
      deq_cnt <= deq_cnt + 1;
      deq_cyc <= cyc;
    end
    if (q_enq_o && q_deq_o) overlap_cnt <= overlap_cnt + 1;
    if (m_status_prev && !status_out) m_fall_cyc <= cyc;
    if (a_status_prev && !a_status) a_fall_cyc <= cyc;
    if (a_q_enq) begin
      a_enq_cnt <= a_enq_cnt + 1;
      a_enq_cyc <= cyc;
      a_bytes.push_back(a_wdata);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic d);
    data_in = b;
    tick(1);
    write_in = 1'b1;
    dequeue_in = d;
    last_wr_cyc = cyc;
    tick(5);
    write_in = 1'b0;
    dequeue_in = 1'b0;
    tick(5);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i], 1'b0);
  endtask

  task automatic pulse_enq();
    enqueue_in = 1'b1;
    tick(5);
    enqueue_in = 1'b0;
    tick(5);
  endtask

  task automatic pulse_deq();
    dequeue_in = 1'b1;
    tick(5);
    dequeue_in = 1'b0;
    tick(5);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(3);
  endtask

  task automatic test_reset();
    q_full = 1'b0;
    rst = 1'b0;
    tick(4);
    tests++; if (status_out !== 1'b0) begin fails++; $display("FAIL reset_status got %b want 0", status_out); end
    tests++; if (q_enq_o !== 1'b0 || q_deq_o !== 1'b0) begin fails++; $display("FAIL reset_strobes got %b%b want 00", q_enq_o, q_deq_o); end
    tests++; if (q_wdata_o !== 8'h00) begin fails++; $display("FAIL reset_wdata got %h want 00", q_wdata_o); end
    tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", err_o); end
    rst = 1'b1;
    tick(1);
    tests++; if (status_out !== 1'b1) begin fails++; $display("FAIL reset_release_status got %b want 1", status_out); end
  endtask

  task automatic test_basic();
    int e0;
    logic [7:0] v;
    v = 8'hAA;
    e0 = enq_cnt;
    for (int i = 0; i < 7; i++) send_bit(v[i], 1'b0);
    tests++; if (status_out !== 1'b1) begin fails++; $display("FAIL basic_status_7bits got %b want 1", status_out); end
    send_bit(v[7], 1'b0);
    tests++; if (status_out !== 1'b0) begin fails++; $display("FAIL basic_status_8bits got %b want 0", status_out); end
    tests++; if (m_fall_cyc !== last_wr_cyc + 4) begin fails++; $display("FAIL basic_hold_latency got %0d want %0d", m_fall_cyc - last_wr_cyc, 4); end
    tests++; if (q_wdata_o !== 8'hAA) begin fails++; $display("FAIL basic_wdata got %h want aa", q_wdata_o); end
    tests++; if (enq_cnt !== e0) begin fails++; $display("FAIL basic_no_early_enq got %0d want 0", enq_cnt - e0); end
    pulse_enq();
    tests++; if (enq_cnt !== e0 + 1) begin fails++; $display("FAIL basic_enq_count got %0d want 1", enq_cnt - e0); end
    tests++; if (enq_bytes[e0] !== 8'hAA) begin fails++; $display("FAIL basic_enq_byte got %h want aa", enq_bytes[e0]); end
    tests++; if (status_out !== 1'b1) begin fails++; $display("FAIL basic_status_back got %b want 1", status_out); end
  endtask

  task automatic test_full_reject();
    int e0;
    e0 = enq_cnt;
    send_byte(8'hAA);
    q_full = 1'b1;
    pulse_enq();
    tests++; if (enq_cnt !== e0) begin fails++; $display("FAIL full_no_enq got %0d want 0", enq_cnt - e0); end
    tests++; if (err_o !== 1'b1) begin fails++; $display("FAIL full_err got %b want 1", err_o); end
    tests++; if (q_wdata_o !== 8'hAA) begin fails++; $display("FAIL full_wdata_kept got %h want aa", q_wdata_o); end
    q_full = 1'b0;
    pulse_enq();
    tests++; if (enq_cnt !== e0 + 1) begin fails++; $display("FAIL full_retry_enq got %0d want 1", enq_cnt - e0); end
    tests++; if (enq_bytes[e0] !== 8'hAA) begin fails++; $display("FAIL full_retry_byte got %h want aa", enq_bytes[e0]); end
    tests++; if (err_o !== 1'b1) begin fails++; $display("FAIL full_err_sticky got %b want 1", err_o); end
    do_reset();
    tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL full_err_cleared got %b want 0", err_o); end
  endtask

  task automatic test_auto_enq();
    int a0, e0;
    do_reset();
    a0 = a_enq_cnt;
    e0 = enq_cnt;
    send_byte(8'h5A);
    tick(3);
    tests++; if (a_enq_cnt !== a0 + 1) begin fails++; $display("FAIL auto_enq_count got %0d want 1", a_enq_cnt - a0); end
    tests++; if (a_bytes[a0] !== 8'h5A) begin fails++; $display("FAIL auto_enq_byte got %h want 5a", a_bytes[a0]); end
    tests++; if (a_enq_cyc !== a_fall_cyc + 1) begin fails++; $display("FAIL auto_enq_latency got %0d want 1", a_enq_cyc - a_fall_cyc); end
    tests++; if (enq_cnt !== e0) begin fails++; $display("FAIL manual_waits got %0d want 0", enq_cnt - e0); end
    tests++; if (a_status !== 1'b1) begin fails++; $display("FAIL auto_status_back got %b want 1", a_status); end
    do_reset();
  endtask

  task automatic test_deq();
    int d0, c0;
    d0 = deq_cnt;
    q_empty = 1'b1;
    pulse_deq();
    tests++; if (deq_cnt !== d0) begin fails++; $display("FAIL deq_empty_no_strobe got %0d want 0", deq_cnt - d0); end
    tests++; if (err_o !== 1'b1) begin fails++; $display("FAIL deq_empty_err got %b want 1", err_o); end
    do_reset();
    q_empty = 1'b0;
    d0 = deq_cnt;
    c0 = cyc;
    dequeue_in = 1'b1;
    tick(6);
    dequeue_in = 1'b0;
    tick(4);
    tests++; if (deq_cnt !== d0 + 1) begin fails++; $display("FAIL deq_count got %0d want 1", deq_cnt - d0); end
    tests++; if (deq_cyc !== c0 + 3) begin fails++; $display("FAIL deq_latency got %0d want 3", deq_cyc - c0); end
    tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL deq_ok_err got %b want 0", err_o); end
  endtask

  task automatic test_back_to_back();
    int d0, e0, c0;
    logic [7:0] v;
    do_reset();
    v = 8'($urandom);
    send_byte(v);
    q_empty = 1'b0;
    d0 = deq_cnt;
    e0 = enq_cnt;
    c0 = cyc;
    enqueue_in = 1'b1;
    dequeue_in = 1'b1;
    tick(6);
    enqueue_in = 1'b0;
    dequeue_in = 1'b0;
    tick(6);
    tests++; if (deq_cnt !== d0 + 1 || enq_cnt !== e0 + 1) begin fails++; $display("FAIL simul_counts got deq %0d enq %0d want 1 1", deq_cnt - d0, enq_cnt - e0); end
    tests++; if (deq_cyc !== c0 + 3) begin fails++; $display("FAIL simul_deq_cycle got %0d want 3", deq_cyc - c0); end
    tests++; if (enq_cyc !== deq_cyc + 1) begin fails++; $display("FAIL simul_enq_after_deq got %0d want 1", enq_cyc - deq_cyc); end
    tests++; if (enq_bytes[e0] !== v) begin fails++; $display("FAIL simul_byte got %h want %h", enq_bytes[e0], v); end
    tests++; if (overlap_cnt !== 0) begin fails++; $display("FAIL simul_overlap got %0d want 0", overlap_cnt); end
  endtask

  task automatic test_reset_mid();
    int d0, e0;
    do_reset();
    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
    d0 = deq_cnt;
    e0 = enq_cnt;
    rst = 1'b0;
    tick(3);
    tests++; if (q_wdata_o !== 8'h00 || status_out !== 1'b0) begin fails++; $display("FAIL mid_reset_outputs got %h %b want 00 0", q_wdata_o, status_out); end
    rst = 1'b1;
    tick(3);
    send_byte(8'hFF);
    pulse_enq();
    tests++; if (enq_cnt !== e0 + 1 || deq_cnt !== d0) begin fails++; $display("FAIL mid_strobes got enq %0d deq %0d want 1 0", enq_cnt - e0, deq_cnt - d0); end
    tests++; if (enq_bytes[e0] !== 8'hFF) begin fails++; $display("FAIL mid_first_byte got %h want ff", enq_bytes[e0]); end
  endtask

  task automatic test_random();
    int e0, d0, exp_deq;
    logic exp_err;
    logic [7:0] exp_bytes[$];
    logic [7:0] v;
    logic dd;
    int dpos;
    do_reset();
    e0 = enq_cnt;
    d0 = deq_cnt;
    exp_deq = 0;
    exp_err = 1'b0;
    for (int n = 0; n < 6; n++) begin
      v = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        q_full = 1'b1;
        tick(1);
        send_bit(1'($urandom_range(0, 1)), 1'b0);
        q_full = 1'b0;
        tick(2);
      end
      dd = 1'($urandom_range(0, 1));
      dpos = $urandom_range(0, 7);
      q_empty = 1'($urandom_range(0, 1));
      if (dd) begin
        if (q_empty) exp_err = 1'b1;
        else exp_deq++;
      end
      for (int i = 0; i < 8; i++) send_bit(v[i], dd && (i == dpos));
      if ($urandom_range(0, 1) == 1) send_bit(1'($urandom_range(0, 1)), 1'b0);
      if ($urandom_range(0, 1) == 1) begin
        q_full = 1'b1;
        pulse_enq();
        q_full = 1'b0;
        exp_err = 1'b1;
      end
      pulse_enq();
      exp_bytes.push_back(v);
      tests++; if (enq_bytes.size() !== e0 + exp_bytes.size() || enq_bytes[enq_bytes.size() - 1] !== v) begin fails++; $display("FAIL rand_byte_%0d got %h want %h", n, enq_bytes[enq_bytes.size() - 1], v); end
    end
    tests++; if (enq_cnt - e0 !== exp_bytes.size()) begin fails++; $display("FAIL rand_enq_count got %0d want %0d", enq_cnt - e0, exp_bytes.size()); end
    tests++; if (deq_cnt - d0 !== exp_deq) begin fails++; $display("FAIL rand_deq_count got %0d want %0d", deq_cnt - d0, exp_deq); end
    tests++; if (err_o !== exp_err) begin fails++; $display("FAIL rand_err got %b want %b", err_o, exp_err); end
    tests++; if (overlap_cnt !== 0) begin fails++; $display("FAIL rand_overlap got %0d want 0", overlap_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_reject();
    test_auto_enq();
    test_deq();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
